// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared size encodings, FSM state type and lane helper functions
//            for the load/store unit memory master.
// Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_ILL = 2'd3;

    // Request sequencing states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Byte-lane mask for an access of the given size at byte offset off
    function automatic logic [3:0] size_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // True when the access cannot be issued: illegal size or unnatural alignment
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_master_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_master_if
// Purpose  : Request, response and data-memory bundle of the LSU back end.
//            master = the LSU itself, slave = execute stage / memory side.
// Revision : 1.0  initial release
// ============================================================================
interface lsu_mem_master_if #(
    parameter int ADDR_W = 32
);
    // Request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    // Response channel
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    // Data-memory port
    logic              mem_read_en;
    logic              mem_write_en;
    logic [3:0]        mem_mark;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport master (
        input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_read_en, mem_write_en, mem_mark, mem_addr, mem_write_data,
        input  mem_read_data
    );

    modport slave (
        output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_read_en, mem_write_en, mem_mark, mem_addr, mem_write_data,
        output mem_read_data
    );
endinterface
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Purpose  : Selects the addressed byte/half lane of a memory word and
//            sign- or zero-extends it to 32 bits. Purely combinational.
// Revision : 1.0  initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  wire logic [31:0] i_word,
    input  wire logic [1:0]  i_off,
    input  wire logic [1:0]  i_size,
    input  wire logic        i_unsigned,
    output logic      [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection; half loads only reach here 2-byte aligned, so off[1] picks the half
    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_word[{i_off[1], 4'b0000} +: 16];
    end

    // Extension by access size; word loads pass straight through
    always_comb begin
        o_result = i_word;
        case (i_size)
            SZ_B:    o_result = {{24{w_byte[7]  & ~i_unsigned}}, w_byte};
            SZ_H:    o_result = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default: o_result = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_master
// Purpose  : LSU back end. Accepts one load/store at a time, issues a single
//            word-aligned memory strobe, captures the read data one cycle
//            later, extends it and returns a response.
// Revision : 1.0  initial release
// ============================================================================
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  wire logic         clock,
    input  wire logic         reset,   // active-low, synchronous
    lsu_mem_master_if.master  bus
);

    // Only a 32-bit data path is implemented
    generate
        if (DATA_W != 32) begin : g_data_w_check
            $error("lsu_mem_master: DATA_W must be 32");
        end
    endgenerate

    lsu_state_e        r_state_q, w_state_d;
    logic              r_wen_q,   w_wen_d;
    logic [1:0]        r_size_q,  w_size_d;
    logic              r_uns_q,   w_uns_d;
    logic [ADDR_W-1:0] r_addr_q,  w_addr_d;
    logic [31:0]       r_wdata_q, w_wdata_d;
    logic              r_err_q,   w_err_d;
    logic [31:0]       r_rdata_q, w_rdata_d;

    logic [31:0]       w_load_result;
    logic [31:0]       w_lane_wdata;
    logic              w_issue;

    lsu_load_align u_load_align (
        .i_word     (bus.mem_read_data),
        .i_off      (r_addr_q[1:0]),
        .i_size     (r_size_q),
        .i_unsigned (r_uns_q),
        .o_result   (w_load_result)
    );

    // Next-state and holding-register update for the request sequencer
    always_comb begin
        w_state_d = r_state_q;
        w_wen_d   = r_wen_q;
        w_size_d  = r_size_q;
        w_uns_d   = r_uns_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_err_d   = r_err_q;
        w_rdata_d = r_rdata_q;
        case (r_state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_wen_d   = bus.req_wen;
                    w_size_d  = bus.req_size;
                    w_uns_d   = bus.req_unsigned;
                    w_addr_d  = bus.req_addr;
                    w_wdata_d = bus.req_wdata;
                    w_rdata_d = 32'h0;
                    w_err_d   = misaligned(bus.req_size, bus.req_addr[1:0]);
                    // Faulting requests skip the memory entirely
                    w_state_d = w_err_d ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_d = r_wen_q ? ST_RESP : ST_DATA;
            ST_DATA: begin
                w_rdata_d = w_load_result;
                w_state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // State and holding registers; reset clears everything
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state_q <= ST_IDLE;
            r_wen_q   <= 1'b0;
            r_size_q  <= 2'b00;
            r_uns_q   <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= 32'h0;
            r_err_q   <= 1'b0;
            r_rdata_q <= 32'h0;
        end else begin
            r_state_q <= w_state_d;
            r_wen_q   <= w_wen_d;
            r_size_q  <= w_size_d;
            r_uns_q   <= w_uns_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_err_q   <= w_err_d;
            r_rdata_q <= w_rdata_d;
        end
    end

    // Store data replicated across lanes so unmasked lanes carry defined values
    always_comb begin
        w_lane_wdata = r_wdata_q;
        case (r_size_q)
            SZ_B:    w_lane_wdata = {4{r_wdata_q[7:0]}};
            SZ_H:    w_lane_wdata = {2{r_wdata_q[15:0]}};
            default: w_lane_wdata = r_wdata_q;
        endcase
    end

    assign w_issue = (r_state_q == ST_ISSUE);

    // Handshakes and strobes are suppressed combinationally while reset is held
    assign bus.req_ready      = reset && (r_state_q == ST_IDLE);
    assign bus.resp_valid     = reset && (r_state_q == ST_RESP);
    assign bus.mem_read_en    = reset && w_issue && !r_wen_q;
    assign bus.mem_write_en   = reset && w_issue &&  r_wen_q;
    assign bus.mem_mark       = w_issue ? size_mask(r_size_q, r_addr_q[1:0]) : 4'b0000;
    assign bus.mem_addr       = {r_addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_write_data = (w_issue && r_wen_q) ? w_lane_wdata : 32'h0;
    assign bus.resp_rdata     = r_rdata_q;
    assign bus.resp_err       = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_master
// Purpose  : Directed self-checking bench for lsu_mem_master.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_mem_master;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lsu_mem_master_if #(.ADDR_W(32)) bus ();

    lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.master)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] mem_word = 32'h0;

    // Strobe monitor: cumulative counts and the last presented memory fields
    int          n_rd = 0;
    int          n_wr = 0;
    logic [31:0] cap_addr  = 32'h0;
    logic [31:0] cap_wdata = 32'h0;
    logic [3:0]  cap_mark  = 4'h0;

    // Registered memory: read data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (bus.mem_read_en) bus.mem_read_data <= mem_word;
    end

    always @(negedge clk) begin
        if (bus.mem_read_en || bus.mem_write_en) begin
            if (bus.mem_read_en)  n_rd++;
            if (bus.mem_write_en) n_wr++;
            cap_addr  = bus.mem_addr;
            cap_wdata = bus.mem_write_data;
            cap_mark  = bus.mem_mark;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic start_req(input logic wen, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_wen      = wen;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
    endtask

    // Accept on the next rising edge, then count cycles until resp_valid
    task automatic wait_resp(output int lat);
        @(posedge clk);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            bus.req_valid = 1'b0;
            if (bus.resp_valid) break;
        end
        if (!bus.resp_valid) lat = -1;
    endtask

    // One full transaction with resp_ready high; returns at a negedge in IDLE
    task automatic txn(input string tag, input logic wen, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdword, input int exp_lat,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [3:0] exp_mark, input logic [31:0] exp_maddr,
                       input logic [31:0] exp_mwdata);
        int lat;
        int rd0;
        int wr0;
        rd0 = n_rd;
        wr0 = n_wr;
        mem_word = rdword;
        start_req(wen, size, uns, addr, wdata);
        wait_resp(lat);
        check($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s rdata", tag), bus.resp_rdata, exp_rdata);
        check($sformatf("%s err", tag), 32'(bus.resp_err), 32'(exp_err));
        check($sformatf("%s reads", tag), 32'(n_rd - rd0), (!wen && !exp_err) ? 32'd1 : 32'd0);
        check($sformatf("%s writes", tag), 32'(n_wr - wr0), (wen && !exp_err) ? 32'd1 : 32'd0);
        if (!exp_err) begin
            check($sformatf("%s mark", tag), 32'(cap_mark), 32'(exp_mark));
            check($sformatf("%s maddr", tag), cap_addr, exp_maddr);
            if (wen) check($sformatf("%s mwdata", tag), cap_wdata, exp_mwdata);
        end
        @(negedge clk);
        check($sformatf("%s idle ready", tag), 32'(bus.req_ready), 32'd1);
        check($sformatf("%s idle no resp", tag), 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int wr0;
        bus.req_valid    = 1'b0;
        bus.req_wen      = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.resp_ready   = 1'b1;

        // Reset state: handshakes and strobes forced low, registers cleared
        repeat (3) @(negedge clk);
        check("rst req_ready", 32'(bus.req_ready), 32'd0);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst strobes", 32'({bus.mem_read_en, bus.mem_write_en}), 32'd0);
        check("rst rdata", bus.resp_rdata, 32'h0);
        check("rst err", 32'(bus.resp_err), 32'd0);
        check("rst maddr", bus.mem_addr, 32'h0);
        check("rst mark", 32'(bus.mem_mark), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst req_ready", 32'(bus.req_ready), 32'd1);

        //   tag           wen  sz    uns   addr           wdata          memword        lat rdata         err   mark     maddr          mwdata
        txn("lw",         1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h8000_0004, 32'h0);
        txn("lb s",       1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0,         32'h80FF_7F01, 3, 32'hFFFF_FF80, 1'b0, 4'b1000, 32'h8000_0000, 32'h0);
        txn("lbu",        1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0,         32'h80FF_7F01, 3, 32'h0000_0080, 1'b0, 4'b1000, 32'h8000_0000, 32'h0);
        txn("lb pos",     1'b0, 2'd0, 1'b0, 32'h8000_0001, 32'h0,         32'h80FF_7F01, 3, 32'h0000_007F, 1'b0, 4'b0010, 32'h8000_0000, 32'h0);
        txn("lh s",       1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0,         32'h8001_7FFF, 3, 32'hFFFF_8001, 1'b0, 4'b1100, 32'h8000_0000, 32'h0);
        txn("lhu",        1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0,         32'h8001_7FFF, 3, 32'h0000_8001, 1'b0, 4'b1100, 32'h8000_0000, 32'h0);
        txn("sh",         1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h1234_ABCD, 32'h0,         2, 32'h0,         1'b0, 4'b1100, 32'h8000_0000, 32'hABCD_ABCD);
        txn("sb",         1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_005A, 32'h0,         2, 32'h0,         1'b0, 4'b0010, 32'h0000_0100, 32'h5A5A_5A5A);
        txn("lw misalgn", 1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0,         32'h1111_1111, 1, 32'h0,         1'b1, 4'b0000, 32'h0,          32'h0);
        txn("size3",      1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0,         32'h1111_1111, 1, 32'h0,         1'b1, 4'b0000, 32'h0,          32'h0);
        txn("sh misalgn", 1'b1, 2'd1, 1'b0, 32'h8000_0003, 32'hFFFF_FFFF, 32'h0,         1, 32'h0,         1'b1, 4'b0000, 32'h0,          32'h0);

        // Back-pressure: response held for 5 cycles, second request waits
        bus.resp_ready = 1'b0;
        mem_word = 32'h1234_5678;
        start_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);
        wait_resp(lat);
        check("bp latency", 32'(lat), 32'd3);
        wr0 = n_wr;
        start_req(1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) begin
            check("bp hold valid", 32'(bus.resp_valid), 32'd1);
            check("bp hold rdata", bus.resp_rdata, 32'h1234_5678);
            check("bp hold ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        check("bp no accept", 32'(n_wr - wr0), 32'd0);
        check("bp still valid", 32'(bus.resp_valid), 32'd1);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp released ready", 32'(bus.req_ready), 32'd1);
        check("bp released valid", 32'(bus.resp_valid), 32'd0);
        wait_resp(lat);
        check("bp 2nd latency", 32'(lat), 32'd2);
        check("bp 2nd writes", 32'(n_wr - wr0), 32'd1);
        check("bp 2nd maddr", cap_addr, 32'h0000_0020);
        check("bp 2nd mwdata", cap_wdata, 32'hCAFE_F00D);
        check("bp 2nd mark", 32'(cap_mark), 32'hF);
        @(negedge clk);

        // Reset asserted during the ISSUE cycle of a store
        wr0 = n_wr;
        start_req(1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'h1122_3344);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst-issue wen", 32'(bus.mem_write_en), 32'd0);
        check("rst-issue ren", 32'(bus.mem_read_en), 32'd0);
        check("rst-issue ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst-issue idle ready", 32'(bus.req_ready), 32'd1);
        check("rst-issue no resp", 32'(bus.resp_valid), 32'd0);
        check("rst-issue no write", 32'(n_wr - wr0), 32'd0);
        @(negedge clk);
        check("rst-issue stays idle", 32'(bus.resp_valid), 32'd0);

        txn("recover lw", 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0BAD_F00D, 3, 32'h0BAD_F00D, 1'b0, 4'b1111, 32'hFFFF_FFFC, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit back end inside the CPU core; it is the initiator that drives the core's data-memory port.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Converts each request into a single word-aligned memory strobe with byte mask and lane-shifted write data.
- Captures the registered read data the cycle after the strobe, extracts and extends it, and returns a response over a valid/ready handshake.

Parameters:
- ADDR_W, 32, byte address width of request and memory port.
- DATA_W, 32, data width; only 32 is supported, elaboration error otherwise.

Ports:
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-low; 0 = reset asserted
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 = illegal
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores/errors
- resp_err  out  1  misaligned or illegal size; no memory access made
- mem_read_en  out  1  read strobe, one cycle per load
- mem_write_en  out  1  write strobe, one cycle per store
- mem_mark  out  4  byte-lane mask
- mem_addr  out  ADDR_W  {req_addr[ADDR_W-1:2],2'b00}
- mem_write_data  out  32  store data shifted to lane
- mem_read_data  in  32  memory data, valid the cycle after mem_read_en

Behaviour:
- States: IDLE, ISSUE, DATA, RESP.
- reset==0 at an edge: state goes to IDLE and all holding registers clear to 0.
- In any cycle with reset==0, mem_read_en, mem_write_en, resp_valid and req_ready are forced to 0 combinationally.
- Other outputs reset to 0.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register all request fields.
  - Error check: size==3, size==1 with addr[0]!=0, or size==2 with addr[1:0]!=0 -> RESP with resp_err=1.
  - Otherwise -> ISSUE.
- ISSUE:
  - Exactly one of mem_read_en/mem_write_en is 1 for this one cycle.
  - mem_addr, mem_mark and mem_write_data are stable this cycle.
  - Mark: byte = 4'b0001<<a[1:0]; half = 4'b0011<<a[1:0]; word = 4'b1111.
  - Write data: req_wdata<<(8*a[1:0]), with the source replicated (byte x4, half x2) so unmasked lanes carry defined values.
  - Loads also present mark for lane information.
  - Store -> RESP. Load -> DATA.
- DATA:
  - mem_read_data is valid; lane extracted by a[1:0] and size.
  - Sign-extended unless req_unsigned; word loads pass through.
  - Result registered into resp_rdata -> RESP.
- RESP:
  - resp_valid=1; resp_rdata/resp_err held stable until resp_valid&&resp_ready.
  - On that handshake -> IDLE.
  - req_ready=0 throughout; no overlap between requests.
- Latency, counted from the acceptance edge to the first resp_valid cycle: load 3 cycles, store 2, error 1.
- Minimum back-to-back period with resp_ready tied high: load 4, store 3 cycles.
- Addresses are never incremented, so there is no wrap-around; high address bits pass through unchanged.
- Reset mid-ISSUE: no strobe is visible that cycle. Reset mid-RESP: the response is dropped.
- All outputs are derived from state or registers only; no combinational path from req_* or resp_ready to mem_*.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_B=0, SZ_H=1, SZ_W=2.
  - state enum.
  - functions size_mask(size, off) and misaligned(size, off).
- Sub-module lsu_load_align: combinational; inputs word, off[1:0], size, unsigned; output 32-bit extended result. Instantiated once in DATA.

Test Plan:
- Load word at addr 0x80000004, mem returns 0xDEADBEEF:
  - mem_read_en pulses 1 cycle, mem_addr=0x80000004, mem_mark=4'b1111.
  - resp_rdata=0xDEADBEEF, resp_err=0, 3 cycles after accept.
- Signed byte load at 0x80000003, mem_read_data=0x80FF7F01:
  - mark=4'b1000, resp_rdata=0xFFFFFF80.
  - Same with req_unsigned=1 -> 0x00000080.
- Store half 0x1234ABCD at 0x80000002:
  - mem_write_en 1 cycle, mark=4'b1100, mem_write_data=0xABCDABCD, mem_addr=0x80000000.
  - resp_valid 2 cycles after accept, resp_rdata=0.
- Misaligned word load at 0x80000001, then size=3:
  - resp_err=1 one cycle after accept; mem_read_en/mem_write_en never asserted.
- Back-pressure: resp_ready=0 for 5 cycles:
  - resp_valid and resp_rdata stay constant; req_ready=0 throughout; a second req_valid is not accepted until the cycle after the handshake.
- Drive reset=0 during the ISSUE cycle of a store:
  - mem_write_en=0 that cycle; state is IDLE after the edge; req_ready=1 once reset=1.
